solar_tracker_control: RTL and testbench
========================================

Name: solar_tracker_control

Overview:
- Consumes the four latched directional lux readings (north/east/south/west) and the solar-panel temperature produced by the I2C sensor-polling controller.
- Drives a two-axis stepper tracker (azimuth east/west, elevation north/south) toward the brighter side, one step per axis per decision.
- Applies a deadband, pulse timing, position soft-limits and a settle interval between decisions.
- Sits between the sensor-polling block and the external stepper drivers.

Parameters:
- DEADBAND, 16'd64: minimum lux difference that triggers a step.
- STEP_DIV, 32'd50000: clk cycles step is high, and again low, per pulse.
- SETTLE_CYCLES, 32'd1000000: clk cycles of wait after each decision.
- POS_MAX, 10'd1023: upper soft-limit of both position counters.
- STOW_TEMP, 9'sd160: stow threshold, signed 0.5 °C LSB (80 °C); used only with the optional feature.

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- enable  input  1  tracking enable, level-sensitive
- n_lux  input  16  north lux, unsigned
- e_lux  input  16  east lux, unsigned
- s_lux  input  16  south lux, unsigned
- w_lux  input  16  west lux, unsigned
- solar_celcius  input  9  panel temperature, two's complement, 0.5 °C LSB
- az_step  output  1  azimuth step pulse
- az_dir  output  1  1 = toward east (az_pos increments); 0 = toward west
- el_step  output  1  elevation step pulse
- el_dir  output  1  1 = toward south (el_pos increments); 0 = toward north
- az_pos  output  10  azimuth position count
- el_pos  output  10  elevation position count
- busy  output  1  high whenever state != IDLE
- stowed  output  1  stow active (constant 0 without the optional feature)

Behaviour:
- Reset: all outputs 0, az_pos = el_pos = 0, counters 0, state IDLE. Reset asserted mid-operation aborts immediately; the step line drops in the next cycle.
- States: IDLE, COMPARE, AZ_HI, AZ_LO, EL_HI, EL_LO, SETTLE.
- IDLE: if enable = 1, go to COMPARE next cycle; otherwise stay.
- COMPARE (one cycle):
  - Snapshot all four lux inputs; all later decisions use the snapshot.
  - Comparisons are 17-bit (zero-extended sums, no overflow).
  - Azimuth: e > w + DEADBAND → want east, az_dir = 1. w > e + DEADBAND → want west, az_dir = 0. Otherwise no azimuth move.
  - Elevation: s > n + DEADBAND → el_dir = 1. n > s + DEADBAND → el_dir = 0. Otherwise no elevation move.
  - A move is blocked if az_pos/el_pos = POS_MAX with dir 1, or = 0 with dir 0.
  - Next state: AZ_HI if an azimuth move is wanted and not blocked; else EL_HI under the same condition; else SETTLE.
  - Direction lines are updated only for an unblocked move and are held through the pulse.
- AZ_HI: az_step = 1 for STEP_DIV cycles, then AZ_LO.
- AZ_LO: on entry, az_pos ±1 per az_dir. az_step = 0 for STEP_DIV cycles, then EL_HI if an elevation move is pending, else SETTLE.
- EL_HI / EL_LO: identical to AZ_HI / AZ_LO on the elevation signals; EL_LO exits to SETTLE.
- SETTLE: count SETTLE_CYCLES, then IDLE. A new decision therefore requires a fresh enable check.
- Latency: enable rising in IDLE at cycle 0 → COMPARE at cycle 1 → az_step high at cycle 2.
- enable dropped mid-pulse: the current HI/LO pair completes and the position is updated. Then go to IDLE directly; skip the pending elevation move and SETTLE.
- enable dropped in SETTLE: go to IDLE next cycle.
- Position never wraps: counters saturate at 0 and POS_MAX.
- Lux input changes outside the COMPARE cycle are ignored.

Optional Feature:
- Macro: TRACKER_OVERTEMP_STOW_EN.
- Defined:
  - COMPARE evaluates $signed(solar_celcius) > STOW_TEMP first.
  - If true: stowed = 1; ignore lux; step toward 0 on both axes (az first, then el), one step each per decision, until both positions are 0.
  - stowed clears in the first COMPARE where the temperature is ≤ STOW_TEMP.
- Undefined: solar_celcius is unused, stowed is tied to 0, and no stow logic is synthesized.

Test Plan (STEP_DIV=4, SETTLE_CYCLES=8, POS_MAX=3, DEADBAND=64):
- Reset held 3 cycles, enable = 0 → all outputs 0, busy = 0 for 20 cycles.
- e=1000, w=100, n=s=500, enable=1 → az_dir=1; az_step high cycles 2–5; az_pos 0→1 at cycle 6; no el_step; busy drops after SETTLE.
- e=100, w=150, n=500, s=100 → no azimuth pulse; el_dir=0 at el_pos=0 is blocked, so no el_step; SETTLE then IDLE.
- e=1000, w=0 held, enable=1 → az_pos climbs 1, 2, 3 and then stays at 3; no further az_step pulses.
- e=65535, w=65472 (diff 63) → no step. e=65535, w=65470 (diff 65) → step with az_dir=1; no overflow.
- Feature on: az_pos=el_pos=2, solar_celcius=9'd170 → stowed=1; az steps to 0 then el steps to 0, one step each per decision; temperature 9'd100 → stowed=0 at the next COMPARE.

Source files
------------

// File: rtl/solar_tracker_control.sv
// Two-axis lux-balancing stepper tracker: compares opposing lux pairs, pulses one step per axis per decision, then settles.
// Optional over-temperature stow (drive both axes home) is built when TRACKER_OVERTEMP_STOW_EN is defined.
module solar_tracker_control #(
    parameter logic [15:0]        DEADBAND      = 16'd64,
    parameter logic [31:0]        STEP_DIV      = 32'd50000,
    parameter logic [31:0]        SETTLE_CYCLES = 32'd1000000,
    parameter logic [9:0]         POS_MAX       = 10'd1023,
    parameter logic signed [8:0]  STOW_TEMP     = 9'sd160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] n_lux,
    input  logic [15:0] e_lux,
    input  logic [15:0] s_lux,
    input  logic [15:0] w_lux,
    input  logic [8:0]  solar_celcius,
    output logic        az_step,
    output logic        az_dir,
    output logic        el_step,
    output logic        el_dir,
    output logic [9:0]  az_pos,
    output logic [9:0]  el_pos,
    output logic        busy,
    output logic        stowed
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COMPARE = 3'd1;
    localparam logic [2:0] AZ_HI   = 3'd2;
    localparam logic [2:0] AZ_LO   = 3'd3;
    localparam logic [2:0] EL_HI   = 3'd4;
    localparam logic [2:0] EL_LO   = 3'd5;
    localparam logic [2:0] SETTLE  = 3'd6;

    logic [2:0]  state;
    logic [31:0] cnt;
    logic        el_pend;

    // 17-bit compares so lux + DEADBAND can never overflow
    logic [16:0] e17, w17, n17, s17, db17;
    logic        want_east, want_west, want_south, want_north;
    logic        az_want, el_want, az_dir_n, el_dir_n, az_go, el_go;
    logic        step_done, settle_done;

    assign e17  = {1'b0, e_lux};
    assign w17  = {1'b0, w_lux};
    assign n17  = {1'b0, n_lux};
    assign s17  = {1'b0, s_lux};
    assign db17 = {1'b0, DEADBAND};

    assign want_east  = e17 > (w17 + db17);
    assign want_west  = w17 > (e17 + db17);
    assign want_south = s17 > (n17 + db17);
    assign want_north = n17 > (s17 + db17);

`ifdef TRACKER_OVERTEMP_STOW_EN
    logic stow_hot;
    assign stow_hot = $signed(solar_celcius) > STOW_TEMP;
`else
    logic unused_temp;
    assign unused_temp = ^solar_celcius;
`endif

    always_comb begin
        az_want  = want_east | want_west;
        az_dir_n = want_east;
        el_want  = want_south | want_north;
        el_dir_n = want_south;
`ifdef TRACKER_OVERTEMP_STOW_EN
        // Overheated: lux is ignored and both axes walk back toward home
        if (stow_hot) begin
            az_want  = (az_pos != 10'd0);
            az_dir_n = 1'b0;
            el_want  = (el_pos != 10'd0);
            el_dir_n = 1'b0;
        end
`endif
    end

    assign az_go = az_want && !(az_dir_n ? (az_pos == POS_MAX) : (az_pos == 10'd0));
    assign el_go = el_want && !(el_dir_n ? (el_pos == POS_MAX) : (el_pos == 10'd0));

    assign step_done   = (cnt == STEP_DIV - 32'd1);
    assign settle_done = (cnt == SETTLE_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 32'd0;
            el_pend <= 1'b0;
            az_dir  <= 1'b0;
            el_dir  <= 1'b0;
            az_pos  <= 10'd0;
            el_pos  <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= 32'd0;
                    if (enable) state <= COMPARE;
                end
                COMPARE: begin
                    cnt     <= 32'd0;
                    el_pend <= el_go;
                    if (az_go) az_dir <= az_dir_n;
                    if (el_go) el_dir <= el_dir_n;
                    state <= az_go ? AZ_HI : (el_go ? EL_HI : SETTLE);
                end
                AZ_HI: begin
                    if (step_done) begin
                        cnt   <= 32'd0;
                        state <= AZ_LO;
                        if (az_dir && az_pos != POS_MAX)  az_pos <= az_pos + 10'd1;
                        else if (!az_dir && az_pos != 10'd0) az_pos <= az_pos - 10'd1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                AZ_LO: begin
                    if (step_done) begin
                        cnt   <= 32'd0;
                        state <= !enable ? IDLE : (el_pend ? EL_HI : SETTLE);
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                EL_HI: begin
                    if (step_done) begin
                        cnt   <= 32'd0;
                        state <= EL_LO;
                        if (el_dir && el_pos != POS_MAX)  el_pos <= el_pos + 10'd1;
                        else if (!el_dir && el_pos != 10'd0) el_pos <= el_pos - 10'd1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                EL_LO: begin
                    if (step_done) begin
                        cnt   <= 32'd0;
                        state <= enable ? SETTLE : IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                SETTLE: begin
                    if (!enable || settle_done) begin
                        cnt   <= 32'd0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    cnt   <= 32'd0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TRACKER_OVERTEMP_STOW_EN
    always_ff @(posedge clk) begin
        if (rst)                    stowed <= 1'b0;
        else if (state == COMPARE)  stowed <= stow_hot;
    end
`else
    assign stowed = 1'b0;
`endif

    assign az_step = (state == AZ_HI);
    assign el_step = (state == EL_HI);
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_solar_tracker_control.sv
// Directed bench for solar_tracker_control with STEP_DIV=4, SETTLE_CYCLES=8, POS_MAX=3, DEADBAND=64.
module tb_solar_tracker_control;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] n_lux = 16'd0, e_lux = 16'd0, s_lux = 16'd0, w_lux = 16'd0;
    logic [8:0]  solar_celcius = 9'd0;
    logic        az_step, az_dir, el_step, el_dir, busy, stowed;
    logic [9:0]  az_pos, el_pos;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    solar_tracker_control #(
        .DEADBAND(16'd64), .STEP_DIV(32'd4), .SETTLE_CYCLES(32'd8),
        .POS_MAX(10'd3), .STOW_TEMP(9'sd160)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .n_lux(n_lux), .e_lux(e_lux), .s_lux(s_lux), .w_lux(w_lux),
        .solar_celcius(solar_celcius),
        .az_step(az_step), .az_dir(az_dir), .el_step(el_step), .el_dir(el_dir),
        .az_pos(az_pos), .el_pos(el_pos), .busy(busy), .stowed(stowed)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lux(input int n, input int e, input int s, input int w);
        n_lux = n[15:0]; e_lux = e[15:0]; s_lux = s[15:0]; w_lux = w[15:0];
    endtask

    // One full decision from IDLE; returns 1 if busy never rose or never fell
    task automatic run_decision(output bit timed_out);
        int k;
        timed_out = 1'b0;
        tick();
        enable = 1'b1;
        k = 0;
        while (!busy && k < 10) begin tick(); k++; end
        if (!busy) timed_out = 1'b1;
        k = 0;
        while (busy && k < 100) begin tick(); k++; end
        if (busy) timed_out = 1'b1;
        enable = 1'b0;
    endtask

    task automatic test_reset();
        logic [25:0] got;
        rst = 1'b1; enable = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tick();
            got = {az_step, az_dir, el_step, el_dir, az_pos, el_pos, busy, stowed};
            n_tests++;
            if (got !== 26'd0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: outputs=%h expected 0", c, got);
            end
        end
    endtask

    task automatic test_az_step();
        logic [22:0] got, exp;
        set_lux(500, 1000, 500, 100);
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            got = {az_step, el_step, busy, az_pos, el_pos};
            exp = {(c >= 2 && c <= 5), 1'b0, (c < 18), ((c >= 6) ? 10'd1 : 10'd0), 10'd0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL az_step cycle %0d: got %h expected %h", c, got, exp);
            end
            if (c == 2) begin
                n_tests++;
                if (az_dir !== 1'b1) begin
                    n_fail++;
                    $display("FAIL az_dir_east: got %b expected 1", az_dir);
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_el_blocked();
        logic [22:0] got, exp;
        set_lux(500, 100, 100, 150);
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            got = {az_step, el_step, busy, az_pos, el_pos};
            exp = {1'b0, 1'b0, (c < 10), 10'd1, 10'd0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL el_blocked cycle %0d: got %h expected %h", c, got, exp);
            end
        end
        enable = 1'b0;
        n_tests++;
        if (el_dir !== 1'b0) begin
            n_fail++;
            $display("FAIL el_dir_blocked: got %b expected 0", el_dir);
        end
    endtask

    task automatic test_deadband_edge();
        logic [22:0] got, exp;
        set_lux(500, 65535, 500, 65472);
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            got = {az_step, el_step, busy, az_pos, el_pos};
            exp = {1'b0, 1'b0, (c < 10), 10'd1, 10'd0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL deadband63 cycle %0d: got %h expected %h", c, got, exp);
            end
        end
        enable = 1'b0;
        set_lux(500, 65535, 500, 65470);
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            got = {az_step, el_step, busy, az_pos, el_pos};
            exp = {(c >= 2 && c <= 5), 1'b0, (c < 18), ((c >= 6) ? 10'd2 : 10'd1), 10'd0};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL deadband65 cycle %0d: got %h expected %h", c, got, exp);
            end
        end
        enable = 1'b0;
        n_tests++;
        if (az_dir !== 1'b1) begin
            n_fail++;
            $display("FAIL deadband65_dir: got %b expected 1", az_dir);
        end
    endtask

    task automatic test_saturate();
        int    pulses = 0;
        int    k = 0;
        logic  prev = 1'b0;
        logic [9:0] max_pos = 10'd0;
        set_lux(500, 1000, 500, 0);
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (az_step && !prev) pulses++;
            prev = az_step;
            if (az_pos > max_pos) max_pos = az_pos;
        end
        enable = 1'b0;
        while (busy && k < 30) begin tick(); k++; end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL saturate_idle_timeout: busy=%b expected 0", busy);
        end
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL saturate_pulses: got %0d expected 1", pulses);
        end
        n_tests++;
        if (az_pos !== 10'd3 || max_pos !== 10'd3) begin
            n_fail++;
            $display("FAIL saturate_pos: got %0d max %0d expected 3", az_pos, max_pos);
        end
    endtask

    task automatic test_back_to_back();
        logic [22:0] got, exp;
        set_lux(0, 0, 1000, 1000);
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            got = {az_step, el_step, busy, az_pos, el_pos};
            exp = {(c >= 2 && c <= 5), (c >= 10 && c <= 13), (c < 26),
                   ((c >= 6) ? 10'd2 : 10'd3), ((c >= 14) ? 10'd1 : 10'd0)};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", c, got, exp);
            end
            if (c == 2) begin
                n_tests++;
                if ({az_dir, el_dir} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL b2b_dirs: got az=%b el=%b expected az=0 el=1", az_dir, el_dir);
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_drop();
        logic [22:0] got, exp;
        set_lux(0, 1000, 1000, 0);
        tick();
        enable = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            got = {az_step, el_step, busy, az_pos, el_pos};
            exp = {(c >= 2 && c <= 5), 1'b0, (c < 10), ((c >= 6) ? 10'd3 : 10'd2), 10'd1};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL enable_drop cycle %0d: got %h expected %h", c, got, exp);
            end
            if (c == 3) enable = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        logic [25:0] got;
        set_lux(500, 0, 500, 1000);
        tick();
        enable = 1'b1;
        repeat (3) tick();
        n_tests++;
        if (az_step !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: az_step=%b expected 1", az_step);
        end
        rst = 1'b1;
        tick();
        got = {az_step, az_dir, el_step, el_dir, az_pos, el_pos, busy, stowed};
        n_tests++;
        if (got !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_mid: outputs=%h expected 0", got);
        end
        rst = 1'b0;
        enable = 1'b0;
        tick();
    endtask

`ifdef TRACKER_OVERTEMP_STOW_EN
    task automatic test_stow();
        bit to;
        logic [20:0] got, exp;
        solar_celcius = 9'd0;
        set_lux(0, 1000, 1000, 0);
        for (int d = 1; d <= 6; d++) begin
            if (d == 3) solar_celcius = 9'd170;
            if (d == 6) begin solar_celcius = 9'd100; set_lux(500, 500, 500, 500); end
            run_decision(to);
            // positions after each decision: 1,1 2,2 1,1 0,0 0,0 0,0
            got = {stowed, az_pos, el_pos};
            case (d)
                1:       exp = {1'b0, 10'd1, 10'd1};
                2:       exp = {1'b0, 10'd2, 10'd2};
                3:       exp = {1'b1, 10'd1, 10'd1};
                4, 5:    exp = {1'b1, 10'd0, 10'd0};
                default: exp = {1'b0, 10'd0, 10'd0};
            endcase
            n_tests++;
            if (to || got !== exp) begin
                n_fail++;
                $display("FAIL stow decision %0d: got %h expected %h timeout=%0d", d, got, exp, to);
            end
        end
    endtask
`else
    task automatic test_stow();
        bit to;
        solar_celcius = 9'd170;
        set_lux(500, 500, 500, 500);
        run_decision(to);
        n_tests++;
        if (to || stowed !== 1'b0) begin
            n_fail++;
            $display("FAIL stow_absent: stowed=%b expected 0 timeout=%0d", stowed, to);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_az_step();
        test_el_blocked();
        test_deadband_edge();
        test_saturate();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_stow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
